// File: rtl/std_sram_pkg.sv
// rtl/std_sram_pkg.sv - shared constants for the SRAM controller and its response buffer
package std_sram_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int RSP_DEPTH = 2;
  localparam int RSP_PTR_W = 1;
  localparam int RSP_CNT_W = 2;

endpackage

// File: rtl/std_sram_rsp_fifo.sv
// rtl/std_sram_rsp_fifo.sv - 2-entry read response buffer, valid/ready on both sides
module std_sram_rsp_fifo
  import std_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [RSP_PTR_W-1:0]  wr_ptr;
  logic [RSP_PTR_W-1:0]  rd_ptr;
  logic [RSP_CNT_W-1:0]  count;
  logic                  push;
  logic                  pop;

  assign out_valid = (count != '0);
  // A full buffer still accepts when its head leaves in the same cycle.
  assign in_ready  = (count != RSP_CNT_W'(RSP_DEPTH)) | out_ready;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == RSP_PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + RSP_PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == RSP_PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + RSP_PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + RSP_CNT_W'(1);
        2'b01:   count <= count - RSP_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/std_sram_ctrl.sv
// rtl/std_sram_ctrl.sv - SRAM controller: clears memory after reset, then serves read/write requests
module std_sram_ctrl
  import std_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  in_run;
  logic                  fifo_ready;
  logic                  rsp_push;

  assign in_run = (state == ST_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (&init_cnt) begin
        state <= ST_RUN;
      end
      init_cnt <= init_cnt + ADDR_WIDTH'(1);
    end
  end

  assign req_ready = in_run & fifo_ready;
  assign init_done = in_run;
  assign rsp_push  = req_valid & req_ready & ~req_we;

  // The clear sequence would otherwise drive the SRAM while reset is held.
  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    if (!reset) begin
      if (in_run) begin
        sram_en   = req_valid & req_ready;
        sram_we   = req_we;
        sram_addr = req_addr;
        sram_din  = req_wdata;
      end else begin
        sram_en   = 1'b1;
        sram_we   = 1'b1;
        sram_addr = init_cnt;
      end
    end
  end

  std_sram_rsp_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rsp_push),
    .in_ready (fifo_ready),
    .in_data  (sram_dout),
    .out_valid(rsp_valid),
    .out_ready(rsp_ready),
    .out_data (rsp_rdata)
  );

endmodule

// File: tb/tb_std_sram_ctrl.sv
// tb/tb_std_sram_ctrl.sv - scoreboard bench for std_sram_ctrl with a behavioural SRAM
module tb_std_sram_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];
  logic [DW-1:0] exp_q [$];

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic rand_mode = 1'b0;
  logic dir_rdy = 1'b1;
  logic rnd_rdy = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (sram_en && sram_we) sram_mem[sram_addr] <= sram_din;
  end
  assign sram_dout = sram_mem[sram_addr];
  assign rsp_ready = rand_mode ? rnd_rdy : dir_rdy;

  std_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake, checks hold stability.
  initial begin
    logic          holding = 1'b0;
    logic [DW-1:0] held;
    forever begin
      @(negedge clk);
      if (holding && rsp_valid) check("rsp_hold_stable", rsp_rdata, held);
      holding = 1'b0;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rsp_unexpected: got %0h expected no response", rsp_rdata);
        end else begin
          check("rsp_data", rsp_rdata, exp_q.pop_front());
        end
      end else if (rsp_valid) begin
        holding = 1'b1;
        held    = rsp_rdata;
      end
      @(posedge clk);
      #1 rnd_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // Called one step after a rising edge; returns one step after the accepting edge.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (req_ready) begin
        check("acc_sram_en", sram_en, 1);
        check("acc_sram_addr", sram_addr, addr);
        check("acc_sram_we", sram_we, we);
        if (we) begin
          check("acc_sram_din", sram_din, data);
          ref_mem[addr] = data;
        end else begin
          exp_q.push_back(ref_mem[addr]);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    vectors++;
    miscompares++;
    $display("FAIL req_timeout: got no accept expected accept within 20 cycles");
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Expects reset to have just been released one step after a rising edge.
  task automatic check_init();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("init_en", sram_en, 1);
      check("init_we", sram_we, 1);
      check("init_addr", sram_addr, i);
      check("init_din", sram_din, 0);
      check("init_done_low", init_done, 0);
      check("init_req_ready", req_ready, 0);
    end
    @(negedge clk);
    check("init_done_high", init_done, 1);
    check("run_idle_en", sram_en, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_init_done", init_done, 0);
    check("rst_sram_en", sram_en, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_din", sram_din, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
  endtask

  initial begin
    int c0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    reset = 1'b0;
    check_init();

    // Unwritten location reads back cleared.
    do_req(1'b0, 3'd2, '0);
    drain();

    // Write then immediate read of the same address, latency 1.
    do_req(1'b1, 3'd5, 8'hA5);
    do_req(1'b0, 3'd5, '0);
    @(negedge clk);
    check("lat1_valid", rsp_valid, 1);
    check("lat1_data", rsp_rdata, 8'hA5);
    @(posedge clk);
    #1 drain();

    // Back-pressure: two reads fill the buffer, the third stalls.
    dir_rdy = 1'b0;
    do_req(1'b0, 3'd5, '0);
    do_req(1'b0, 3'd2, '0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd7;
    repeat (2) begin
      @(negedge clk);
      check("full_req_ready", req_ready, 0);
      check("full_rsp_valid", rsp_valid, 1);
      check("full_sram_en", sram_en, 0);
    end
    @(posedge clk);
    #1 dir_rdy = 1'b1;
    do_req(1'b0, 3'd7, '0);
    drain();

    // Full-rate reads.
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, AW'(i), DW'($urandom));
    c0 = cyc;
    for (int i = 0; i < DEPTH; i++) do_req(1'b0, AW'(i), '0);
    check("stream_cycles", cyc - c0, DEPTH);
    drain();

    // Random traffic with random response back-pressure.
    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      do_req(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_mode = 1'b0;
    drain();

    // Reset with two buffered responses: they vanish and memory is cleared again.
    do_req(1'b1, 3'd3, 8'h3C);
    do_req(1'b1, 3'd4, 8'h4D);
    dir_rdy = 1'b0;
    do_req(1'b0, 3'd3, '0);
    do_req(1'b0, 3'd4, '0);
    #1 reset = 1'b1;
    #1 check_reset_outputs();
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    dir_rdy = 1'b1;
    check_init();
    do_req(1'b0, 3'd3, '0);
    do_req(1'b0, 3'd4, '0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/std_sram_ctrl.md
STD_SRAM_CTRL -- requirements
Module: std_sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 1, SRAM address width; depth = 1 << ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 1, SRAM word width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid & req_ready.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  request address.
REQ-009 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rsp_valid  output  1  read data available.
REQ-011 SHALL have port rsp_ready  input  1  consumer takes read data when rsp_valid & rsp_ready.
REQ-012 SHALL have port rsp_rdata  output  DATA_WIDTH  read data.
REQ-013 SHALL have port init_done  output  1  memory clear complete.
REQ-014 SHALL have port sram_en  output  1  SRAM enable.
REQ-015 SHALL have port sram_we  output  1  SRAM write enable.
REQ-016 SHALL have port sram_addr  output  ADDR_WIDTH  SRAM address.
REQ-017 SHALL have port sram_din  output  DATA_WIDTH  SRAM write data.
REQ-018 SHALL have port sram_dout  input  DATA_WIDTH  SRAM combinational read data.

Function
REQ-019 SHALL implement FSM states INIT, RUN; INIT -> RUN after last address cleared; no other transitions except reset.
REQ-020 In INIT, SHALL drive sram_en=1, sram_we=1, sram_din=0, sram_addr=init counter, counter increments 0..depth-1, one address per cycle.
REQ-021 SHALL hold req_ready=0 and init_done=0 throughout INIT; init_done=1 from first RUN cycle onward.
REQ-022 INIT SHALL take exactly depth cycles; init counter wrap at depth-1 SHALL trigger transition, never rewrite address 0.
REQ-023 In RUN, SHALL drive sram_en = req_valid & req_ready, sram_we = req_we, sram_addr = req_addr, sram_din = req_wdata, combinationally.
REQ-024 In RUN, req_ready SHALL be 1 when response buffer has a free slot, or is full with a pop occurring this cycle.
REQ-025 Accepted write SHALL update SRAM at that clock edge and produce no response.
REQ-026 Accepted read SHALL capture sram_dout into a 2-entry response FIFO at that edge; rsp_valid SHALL assert next cycle (latency 1).
REQ-027 Responses SHALL be returned in acceptance order; rsp_rdata SHALL be stable while rsp_valid & !rsp_ready.
REQ-028 Simultaneous push and pop on full buffer SHALL keep count at 2 with no loss; on empty buffer push only (no bypass).
REQ-029 Write followed next cycle by read to same address SHALL return the new data.
REQ-030 Sustained reads with rsp_ready=1 SHALL achieve one accept per cycle.

Reset
REQ-031 Reset assertion SHALL asynchronously force state=INIT, init counter=0, buffer count/pointers=0.
REQ-032 Under reset SHALL output req_ready=0, rsp_valid=0, init_done=0, sram_en=0, sram_we=0, sram_addr=0, sram_din=0, rsp_rdata=0.
REQ-033 Reset mid-INIT or mid-RUN SHALL discard buffered responses and restart full clear after release.

Structure
REQ-034 FSM state encoding and response buffer depth constant SHALL reside in a shared package std_sram_pkg.
REQ-035 Response buffer SHALL be one sub-module std_sram_rsp_fifo (2-entry, valid/ready both sides).

Verification
REQ-036 ADDR_WIDTH=3: release reset -> sram_we=1 for exactly 8 cycles, addr 0..7, din 0; init_done rises cycle 9.
REQ-037 After init, write addr 5 = 0xA5, read addr 5 next cycle -> rsp_rdata=0xA5 one cycle after accept.
REQ-038 Read un-written addr 2 after init -> rsp_rdata=0.
REQ-039 rsp_ready=0, issue 3 reads -> 2 accepted, req_ready=0 on third; raise rsp_ready -> 3 responses in order.
REQ-040 Back-to-back reads addr 0..7, rsp_ready=1 -> 8 accepts in 8 cycles, data in order.
REQ-041 Assert reset with 2 buffered responses -> rsp_valid=0 immediately, full 8-cycle clear reruns, prior data reads 0.
